gray_decoder_top: RTL and testbench



---
 rtl/gray_decoder_top.sv | 104 ++++++++++
 tb/tb_gray_decoder_top.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_top.sv
// gray_decoder_top
//   Converts a 4-bit Gray-code switch input to binary. The result drives
//   four LEDs and is shown as a two-digit decimal value ("00".."15") on a
//   multiplexed two-digit common-anode 7-segment display.
//
// Parameters
//   COUNT_W  width of the free-running display refresh counter
//   SEL_BIT  refresh counter bit used as digit select (0..COUNT_W-1);
//            each digit stays lit for 2^SEL_BIT cycles
//
// Ports
//   clk_pi             in   system clock, rising edge
//   rst_pi             in   synchronous active-high reset
//   codigo_gray_pi     in   [3:0] asynchronous Gray code from the switches
//   anodo_po           out  [1:0] digit enables, active-low (bit0 units, bit1 tens)
//   catodo_po          out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   codigo_bin_led_po  out  [3:0] binary value, active-high LEDs
module gray_decoder_top #(
  parameter int COUNT_W = 6,
  parameter int SEL_BIT = 5
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic [3:0] codigo_gray_pi,
  output logic [1:0] anodo_po,
  output logic [6:0] catodo_po,
  output logic [3:0] codigo_bin_led_po
);

  logic [3:0]         sync1_q;
  logic [3:0]         sync2_q;
  logic [3:0]         bin_q;
  logic [3:0]         bin_next;
  logic [COUNT_W-1:0] cnt_q;
  logic [1:0]         anodo_q;
  logic [6:0]         catodo_q;
  logic               sel;
  logic [3:0]         units;
  logic [3:0]         tens;
  logic [3:0]         digit;

  // Active-low segment pattern for one decimal digit, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_pattern(input logic [3:0] value);
    logic [6:0] pat;
    case (value)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Gray to binary: each binary bit is the XOR of the next higher binary
  // bit and the Gray bit at the same position, walking down from the MSB.
  always_comb begin
    bin_next    = '0;
    bin_next[3] = sync2_q[3];
    for (int unsigned i = 0; i < 3; i++) begin
      bin_next[2-i] = bin_next[3-i] ^ sync2_q[2-i];
    end
  end

  // Value is at most 15, so the tens digit is 0 or 1 and a single compare
  // replaces a divider.
  always_comb begin
    sel   = cnt_q[SEL_BIT];
    units = (bin_q >= 4'd10) ? bin_q - 4'd10 : bin_q;
    tens  = (bin_q >= 4'd10) ? 4'd1 : 4'd0;
    digit = sel ? tens : units;
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      anodo_q  <= '1;
      catodo_q <= '1;
    end else begin
      sync1_q  <= codigo_gray_pi;
      sync2_q  <= sync1_q;
      bin_q    <= bin_next;
      cnt_q    <= cnt_q + COUNT_W'(1);
      // Anode and cathode load on the same edge so a digit never shows
      // the other digit's segments.
      anodo_q  <= sel ? 2'b01 : 2'b10;
      catodo_q <= seg_pattern(digit);
    end
  end

  assign anodo_po          = anodo_q;
  assign catodo_po         = catodo_q;
  assign codigo_bin_led_po = bin_q;

endmodule

// File: tb/tb_gray_decoder_top.sv
module tb_gray_decoder_top;

  localparam int COUNT_W = 6;
  localparam int SEL_BIT = 5;

  logic       clk_pi;
  logic       rst_pi;
  logic [3:0] codigo_gray_pi;
  logic [1:0] anodo_po;
  logic [6:0] catodo_po;
  logic [3:0] codigo_bin_led_po;

  gray_decoder_top #(
    .COUNT_W(COUNT_W),
    .SEL_BIT(SEL_BIT)
  ) dut (
    .clk_pi            (clk_pi),
    .rst_pi            (rst_pi),
    .codigo_gray_pi    (codigo_gray_pi),
    .anodo_po          (anodo_po),
    .catodo_po         (catodo_po),
    .codigo_bin_led_po (codigo_bin_led_po)
  );

  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  typedef struct {
    logic [3:0] led;
    logic [1:0] an;
    logic [6:0] cat;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;

  // Reference model state
  int         hist_g[$];
  bit         hist_r[$];
  int         cyc_n = 0;
  int         led_prev = 0;
  int         since_rst = 0;   // non-reset edges since the last reset
  logic [6:0] seg_tbl [10];

  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
    seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
    seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
    seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
  end

  function automatic int gray2bin(input int g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic bit rst_at(input int n);
    if (n < 0) return 1'b1;
    return hist_r[n];
  endfunction

  function automatic bit model_sel();
    return ((since_rst % (1 << COUNT_W)) >> SEL_BIT) & 1;
  endfunction

  // One clock: drive inputs after the falling edge, then predict the
  // outputs that appear after the rising edge and queue them.
  task automatic step(input logic r, input logic [3:0] g);
    exp_t e;
    int   n;
    int   led_exp;
    bit   s;
    @(negedge clk_pi);
    rst_pi         = r;
    codigo_gray_pi = g;
    @(posedge clk_pi);
    hist_g.push_back(int'(g));
    hist_r.push_back(r);
    n = cyc_n;
    if (rst_at(n) || rst_at(n-1) || rst_at(n-2)) led_exp = 0;
    else led_exp = gray2bin(hist_g[n-2]);
    if (r) begin
      e.an = 2'b11;
      e.cat = 7'b1111111;
      since_rst = 0;
    end else begin
      s = model_sel();
      e.an  = s ? 2'b01 : 2'b10;
      e.cat = s ? seg_tbl[led_prev / 10] : seg_tbl[led_prev % 10];
      since_rst = since_rst + 1;
    end
    e.led = 4'(led_exp);
    e.cyc = n;
    sb_q.push_back(e);
    led_prev = led_exp;
    cyc_n++;
  endtask

  task automatic hold(input logic [3:0] g, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, g);
  endtask

  // Monitor: every falling edge the DUT presents a fresh set of outputs.
  always @(negedge clk_pi) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (codigo_bin_led_po !== e.led) begin
        errors++;
        $display("FAIL led cyc=%0d got=%b exp=%b", e.cyc, codigo_bin_led_po, e.led);
      end
      checks++;
      if (anodo_po !== e.an) begin
        errors++;
        $display("FAIL anodo cyc=%0d got=%b exp=%b", e.cyc, anodo_po, e.an);
      end
      checks++;
      if (catodo_po !== e.cat) begin
        errors++;
        $display("FAIL catodo cyc=%0d got=%b exp=%b", e.cyc, catodo_po, e.cat);
      end
    end
  end

  logic [3:0] sweep [15];
  int         bound;

  initial begin
    rst_pi         = 1'b1;
    codigo_gray_pi = 4'b0101;
    sweep = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
              4'b1000};

    // Reset with a non-zero input present
    step(1'b1, 4'b0101);
    step(1'b1, 4'b0101);
    hold(4'b0000, 4);

    // Conversion sweep, each code held 5 cycles
    foreach (sweep[i]) hold(sweep[i], 5);

    // Decimal display of 15 over a full refresh period plus margin
    hold(4'b1000, 70);

    // Leading zero on 5
    hold(4'b0111, 70);

    // Mid-run reset while the tens digit is lit
    bound = 0;
    while (!model_sel() && bound < 100) begin
      step(1'b0, 4'b1000);
      bound++;
    end
    if (!model_sel()) begin
      errors++;
      $display("FAIL tens_phase_wait got=%0d exp=%0d", model_sel(), 1);
    end
    hold(4'b1000, 3);
    step(1'b1, 4'b1000);
    hold(4'b1000, 70);

    // Randomized inputs with occasional resets
    for (int k = 0; k < 120; k++) begin
      logic [3:0] g;
      g = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) step(1'b1, g);
      end
      hold(g, int'($urandom_range(1, 6)));
    end

    // Drain the scoreboard
    @(negedge clk_pi);
    @(negedge clk_pi);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=%0d", sb_q.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
